// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing a bank of NUM_REGS registers with byte-lane writes,
// per-register read-only protection and SLVERR decoding of bad addresses.
module axi4_lite_slave_regs #(
   parameter int                  ADDR_WIDTH = 32,
   parameter int                  DATA_WIDTH = 32,
   parameter int                  NUM_REGS   = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
   input  logic                           ACLK,
   input  logic                           ARESET,
   input  logic [ADDR_WIDTH-1:0]          AWADDR,
   input  logic                           AWVALID,
   output logic                           AWREADY,
   input  logic [DATA_WIDTH-1:0]          WDATA,
   input  logic [DATA_WIDTH/8-1:0]        WSTRB,
   input  logic                           WVALID,
   output logic                           WREADY,
   output logic [1:0]                     BRESP,
   output logic                           BVALID,
   input  logic                           BREADY,
   input  logic [ADDR_WIDTH-1:0]          ARADDR,
   input  logic                           ARVALID,
   output logic                           ARREADY,
   output logic [DATA_WIDTH-1:0]          RDATA,
   output logic [1:0]                     RRESP,
   output logic                           RVALID,
   input  logic                           RREADY,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            wr_pulse
);

   localparam int ADDR_LSB   = $clog2(DATA_WIDTH / 8);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      WR_IDLE    = 3'd0,
      WR_HAVE_AW = 3'd1,
      WR_HAVE_W  = 3'd2,
      WR_COMMIT  = 3'd3,
      WR_RESP    = 3'd4
   } wr_state_t;

   // Misaligned, beyond the register bank, or with stray upper address bits.
   function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] upper;
      upper = a >> (ADDR_LSB + 8);
      return (a[ADDR_LSB-1:0] != '0) ||
             ({1'b0, a[ADDR_LSB +: 8]} >= 9'(NUM_REGS)) ||
             (upper != '0);
   endfunction

   function automatic logic is_ro(input logic [7:0] idx);
      logic ro;
      ro = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         ro = ro | (RO_MASK[i] & (idx == 8'(i)));
      end
      return ro;
   endfunction

   wr_state_t                     wr_state_r;
   wr_state_t                     wr_state_nxt_s;
   logic [ADDR_WIDTH-1:0]         aw_addr_r;
   logic [DATA_WIDTH-1:0]         w_data_r;
   logic [STRB_WIDTH-1:0]         w_strb_r;
   logic [1:0]                    bresp_r;
   logic [NUM_REGS-1:0]           wr_pulse_r;
   logic [NUM_REGS*DATA_WIDTH-1:0] regs_r;
   logic                          rvalid_r;
   logic [DATA_WIDTH-1:0]         rdata_r;
   logic [1:0]                    rresp_r;

   logic                          aw_hs_s;
   logic                          w_hs_s;
   logic                          ar_hs_s;
   logic                          commit_s;
   logic                          wr_err_s;
   logic [7:0]                    wr_idx_s;
   logic [NUM_REGS-1:0]           wr_sel_s;
   logic [7:0]                    rd_idx_s;
   logic                          rd_err_s;
   logic [DATA_WIDTH-1:0]         rd_mux_s;

   assign AWREADY  = !ARESET && ((wr_state_r == WR_IDLE) || (wr_state_r == WR_HAVE_W));
   assign WREADY   = !ARESET && ((wr_state_r == WR_IDLE) || (wr_state_r == WR_HAVE_AW));
   assign ARREADY  = !ARESET && !rvalid_r;
   assign BVALID   = (wr_state_r == WR_RESP);
   assign BRESP    = bresp_r;
   assign RVALID   = rvalid_r;
   assign RDATA    = rdata_r;
   assign RRESP    = rresp_r;
   assign reg_q    = regs_r;
   assign wr_pulse = wr_pulse_r;

   assign aw_hs_s  = AWVALID && AWREADY;
   assign w_hs_s   = WVALID && WREADY;
   assign ar_hs_s  = ARVALID && ARREADY;
   assign commit_s = (wr_state_r == WR_COMMIT);
   assign wr_idx_s = aw_addr_r[ADDR_LSB +: 8];
   assign wr_err_s = addr_err(aw_addr_r) || is_ro(wr_idx_s);
   assign rd_idx_s = ARADDR[ADDR_LSB +: 8];
   assign rd_err_s = addr_err(ARADDR);

   // Write channel state register.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_state_r <= WR_IDLE;
      end else begin
         wr_state_r <= wr_state_nxt_s;
      end
   end

   // Write next-state: AW and W are accepted in any order, commit, then respond.
   always_comb begin
      wr_state_nxt_s = wr_state_r;
      case (wr_state_r)
         WR_IDLE: begin
            if (aw_hs_s && w_hs_s) begin
               wr_state_nxt_s = WR_COMMIT;
            end else if (aw_hs_s) begin
               wr_state_nxt_s = WR_HAVE_AW;
            end else if (w_hs_s) begin
               wr_state_nxt_s = WR_HAVE_W;
            end else begin
               wr_state_nxt_s = WR_IDLE;
            end
         end
         WR_HAVE_AW: begin
            if (w_hs_s) begin
               wr_state_nxt_s = WR_COMMIT;
            end else begin
               wr_state_nxt_s = WR_HAVE_AW;
            end
         end
         WR_HAVE_W: begin
            if (aw_hs_s) begin
               wr_state_nxt_s = WR_COMMIT;
            end else begin
               wr_state_nxt_s = WR_HAVE_W;
            end
         end
         WR_COMMIT: begin
            wr_state_nxt_s = WR_RESP;
         end
         WR_RESP: begin
            if (BREADY) begin
               wr_state_nxt_s = WR_IDLE;
            end else begin
               wr_state_nxt_s = WR_RESP;
            end
         end
         default: begin
            wr_state_nxt_s = WR_IDLE;
         end
      endcase
   end

   // Capture write address and data on their handshakes.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_addr_r <= '0;
         w_data_r  <= '0;
         w_strb_r  <= '0;
      end else begin
         if (aw_hs_s) begin
            aw_addr_r <= AWADDR;
         end
         if (w_hs_s) begin
            w_data_r <= WDATA;
            w_strb_r <= WSTRB;
         end
      end
   end

   // One-hot select of the register being committed; empty on error.
   always_comb begin
      wr_sel_s = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         wr_sel_s[i] = commit_s && !wr_err_s && (wr_idx_s == 8'(i));
      end
   end

   // Write response and update pulse, both set on the commit edge.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         bresp_r    <= 2'b00;
         wr_pulse_r <= '0;
      end else begin
         wr_pulse_r <= wr_sel_s;
         if (commit_s) begin
            bresp_r <= wr_err_s ? 2'b10 : 2'b00;
         end
      end
   end

   // Register bank with byte-lane updates.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         regs_r <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
               if (wr_sel_s[i] && w_strb_r[b]) begin
                  regs_r[i*DATA_WIDTH + 8*b +: 8] <= w_data_r[8*b +: 8];
               end
            end
         end
      end
   end

   // Read mux; sees pre-commit contents, so a colliding read returns the old value.
   always_comb begin
      rd_mux_s = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         rd_mux_s = rd_mux_s |
                    ((rd_idx_s == 8'(i)) ? regs_r[i*DATA_WIDTH +: DATA_WIDTH] : '0);
      end
   end

   // Read data channel: load on AR handshake, hold until RREADY.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rvalid_r <= 1'b0;
         rdata_r  <= '0;
         rresp_r  <= 2'b00;
      end else if (ar_hs_s) begin
         rvalid_r <= 1'b1;
         rdata_r  <= rd_err_s ? '0 : rd_mux_s;
         rresp_r  <= rd_err_s ? 2'b10 : 2'b00;
      end else if (rvalid_r && RREADY) begin
         rvalid_r <= 1'b0;
      end else begin
         rvalid_r <= rvalid_r;
      end
   end

endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
Parametrised AXI4-Lite slave terminating all five channels, including the read data channel, into a bank of NUM_REGS memory-mapped registers. It adds WSTRB byte-lane writes, independent acceptance of write address and write data, per-register read-only protection, and SLVERR decoding. It sits behind an AXI4-Lite master and exports the register contents and per-register write strobes to the core logic.

Parameters:
ADDR_WIDTH, 32, AWADDR/ARADDR width
DATA_WIDTH, 32, data width; legal values 32 or 64
NUM_REGS, 8, register count; legal range 1..256
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only
ADDR_LSB, derived = log2(DATA_WIDTH/8), number of byte-offset address bits

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  reset, synchronous, active-high
AWADDR  in  ADDR_WIDTH  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte-lane write enables
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response: 00 OKAY, 10 SLVERR
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_WIDTH  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready
reg_q  out  NUM_REGS*DATA_WIDTH  register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
wr_pulse  out  NUM_REGS  one-cycle pulse on bit i when register i is updated

Behaviour:
- Clock and reset: one clock, ACLK. ARESET is synchronous and active-high. Any pending AW, W, B or R transaction is dropped on reset.
- Reset values: all registers 0; BVALID, RVALID, wr_pulse 0; BRESP, RRESP, RDATA 0.
- READY outputs: AWREADY, WREADY and ARREADY are combinational from internal state. They are forced to 0 while ARESET=1 and become 1 on the first cycle after reset release.
- Address decode: idx = addr[ADDR_LSB +: 8].
  - Error if addr[ADDR_LSB-1:0] != 0 (misaligned).
  - Error if idx >= NUM_REGS.
  - Error if any address bits above ADDR_LSB+8 are nonzero.
- Write address channel:
  - AWREADY = !aw_held && !BVALID.
  - On AW handshake, AWADDR is latched and aw_held is set.
- Write data channel:
  - WREADY = !w_held && !BVALID.
  - On W handshake, WDATA and WSTRB are latched and w_held is set.
  - AW and W may arrive in either order or in the same cycle.
- Write commit:
  - Occurs on the first edge where aw_held && w_held && !BVALID.
  - At that edge: BVALID<=1, held flags cleared.
  - If the address is legal and not RO: byte lanes with WSTRB[b]=1 are updated, and wr_pulse[idx]<=1 for that one cycle. WSTRB=0 still pulses wr_pulse and returns OKAY.
  - If the address is illegal or RO_MASK[idx]=1: no update, no pulse, BRESP=10.
  - Latency: AW and W handshaken at edge N gives register update and BVALID=1 at edge N+1.
- Write response: BVALID and BRESP hold until BREADY. BVALID clears on the edge with BVALID&&BREADY.
- Read address channel: ARREADY = !RVALID.
- Read data:
  - AR handshake at edge N gives RVALID=1 at edge N+1, with RDATA = register value before any same-edge commit.
  - Illegal read address: RDATA=0, RRESP=10. RO registers read normally.
  - RVALID, RDATA and RRESP are stable until RREADY. RVALID clears on the handshake edge.
  - Back-to-back reads: one bubble per transaction (ARREADY low while RVALID).
- Simultaneous events: read and write paths are fully independent. A read of register i in the same cycle as a write commit to register i returns the old value. The next read returns the new value.
- Backpressure: BREADY held 0 stalls further writes (AWREADY=WREADY=0 while BVALID). At most one of each channel is held, so there are no overflow cases.
- Unused WSTRB bits and RESP encodings 01/11 are never generated.

Test Plan:
- Reset then idle: ARESET=1 for 2 cycles, then released -> AWREADY=WREADY=ARREADY=1 on the first cycle after release; BVALID=RVALID=0; reg_q=0.
- Simultaneous AW+W: AWADDR=0x8, WDATA=0xDEADBEEF, WSTRB=0xF, BREADY=1 -> at next edge reg2=0xDEADBEEF, wr_pulse=0x04 for one cycle, BVALID=1, BRESP=00. Read 0x8 -> RDATA=0xDEADBEEF, RRESP=00.
- W before AW with partial strobe: W=0x11223344, WSTRB=0x5 first, AW=0x0 three cycles later (reg0=0) -> WREADY=0 while held; after commit reg0=0x00220044.
- Errors: write to 0x20 (idx 8, NUM_REGS=8) -> BRESP=10, no reg change, no pulse. Write to 0x2 (misaligned) -> BRESP=10. Read 0x20 -> RDATA=0, RRESP=10. With RO_MASK=0x02, write to 0x4 -> BRESP=10, reg1 unchanged.
- Backpressure: hold BREADY=0 for 5 cycles after a write -> BVALID and BRESP stable, AWREADY=WREADY=0. Hold RREADY=0 for 4 cycles -> RDATA stable, ARREADY=0.
- Collision and mid-op reset:
  - Read of 0x8 with AR handshake on the same edge as a write commit of 0x5 to 0x8 -> RDATA is the old value; a subsequent read returns 0x5.
  - ARESET asserted while BVALID=1 -> next cycle BVALID=0 and registers are 0.
